pong_frame_renderer: RTL and testbench
======================================

Name: pong_frame_renderer

Overview:
- Parametrised successor to the combinational pong LED compositor.
- Snapshots game state (ball, paddles, scores) at frame start, then streams the W x H frame one row per transfer over a valid/ready interface to the LED matrix driver.
- Adds paddle clamping, decimal score glyphs 0-9 and full-height dashed midline.
- Sits between the game-logic core and the matrix scan driver.

Parameters:
- W, 64, matrix width in pixels (columns); row_data width.
- H, 64, matrix height in rows.
- CW, 6, coordinate width; must satisfy 2**CW >= max(W,H).
- PAD_H, 6, paddle height in rows.
- PAD_W, 2, paddle width in columns.
- PAD_YMIN, 5, lowest legal paddle top row.
- PAD_YMAX, 58, highest legal paddle top row.
- MID_X, 30, left column of the two-column midline.
- DASH_ON, 2, lit rows per dash period.
- DASH_PERIOD, 3, dash period in rows.
- SC1_X, 14, left column of player-1 score glyph.
- SC2_X, 46, left column of player-2 score glyph.
- SC_Y, 1, top row of score glyphs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  request to render one frame.
- bx  in  CW  ball column.
- by  in  CW  ball row.
- p1y  in  CW  player-1 paddle top row (unclamped).
- p2y  in  CW  player-2 paddle top row (unclamped).
- sc1  in  4  player-1 score.
- sc2  in  4  player-2 score.
- row_valid  out  1  row_addr/row_data valid.
- row_ready  in  1  downstream accepts the row.
- row_addr  out  CW  row index of row_data.
- row_data  out  W  pixel bits; bit x = column x.
- frame_busy  out  1  high from snapshot until the last row is accepted.
- frame_done  out  1  one-cycle pulse when the last row is accepted.
- frame_drop  out  1  sticky; set when frame_start is ignored while busy.

Behaviour:
- Reset (synchronous, active-high, wins over all inputs): row_valid=0, row_addr=0, row_data=0, frame_busy=0, frame_done=0, frame_drop=0; FSM returns to IDLE.
  - Reset mid-frame abandons the frame; no frame_done.
- FSM states: IDLE, EMIT.
- IDLE:
  - On frame_start, latch all game inputs into the snapshot.
    - Paddles clamp to [PAD_YMIN, PAD_YMAX].
    - Scores above 9 saturate to 9.
  - Set frame_busy. Next cycle: row 0 registered, row_valid=1 (latency 1), state EMIT.
- EMIT:
  - Hold row_addr/row_data stable while row_valid && !row_ready.
  - On each transfer (valid && ready) with row_addr < H-1, present row_addr+1 on the next cycle with no bubble.
  - On transfer of row H-1: row_valid=0, frame_busy=0, frame_done=1 for one cycle, then IDLE.
  - frame_start in EMIT is ignored and sets frame_drop; only rst clears frame_drop.
  - frame_start on the frame_done cycle is accepted, since the FSM is in IDLE that cycle.
- Input changes during EMIT have no effect; only the snapshot is rendered.
- Pixel composition: OR of all objects, no priority.
  - Ball: bit bx of row by, only if bx<W and by<H.
  - Paddle 1: columns 0..PAD_W-1. Paddle 2: columns W-PAD_W..W-1. Both span rows py..py+PAD_H-1.
  - Midline: columns MID_X and MID_X+1, lit when (row mod DASH_PERIOD) < DASH_ON, for all rows.
  - Scores: 3x5 glyphs at rows SC_Y..SC_Y+4. Glyph bit 2 maps to column SCx, bit 0 to column SCx+2.
  - Any pixel at column >= W or row >= H is discarded.
- Font rows, top to bottom, bit2..bit0:
  - 0=111,101,101,101,111
  - 1=010,010,010,010,010
  - 2=111,001,111,100,111
  - 3=111,001,111,001,111
  - 4=101,101,111,001,001
  - 5=111,100,111,001,111
  - 6=111,100,111,101,111
  - 7=111,001,001,001,001
  - 8=111,101,111,101,111
  - 9=111,101,111,001,111

Optional Feature:
- Macro: PONG_FRAME_BORDER_EN.
- Defined: rows 0 and H-1 are additionally fully lit (all W bits ORed with 1s).
- Undefined: no border; those rows carry only normal objects.

Decomposition:
- Package pong_pkg holds:
  - the 10x5x3 font constant and the glyph lookup function;
  - the FSM state enum (IDLE, EMIT);
  - the clamp and saturate helper functions.
- One sub-module: pong_row_composer. It is combinational: snapshot plus row index in, W-bit row out. The parent registers its output.

Test Plan:
- Reset, then frame_start with bx=10, by=20, p1y=30, p2y=2, sc1=3, sc2=12, row_ready=1:
  - row 0 valid 1 cycle later; rows 0..63 back-to-back; frame_done pulses once.
  - row 20 has bit 10 set.
  - p2 drawn rows 5..10, columns 62-63 (clamped).
  - sc2 rendered as 9.
- Midline pattern: rows 0,1 have bits 30,31 set; row 2 clear; repeats through row 63.
- Backpressure: toggle row_ready randomly:
  - each row_addr appears exactly once, in order;
  - data stays stable while stalled;
  - 64 transfers per frame.
- frame_start at row 17 of EMIT:
  - frame continues unchanged; frame_drop=1 until rst.
  - Changing bx mid-frame does not alter emitted rows.
- Reset asserted at row 40 with row_ready=1:
  - next cycle all outputs 0, no frame_done;
  - new frame_start restarts at row 0.
- Build with PONG_FRAME_BORDER_EN:
  - rows 0 and 63 equal all-ones;
  - without the macro, row 0 equals the midline bits only (sc1=0 glyph starts at SC_Y=1).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong frame renderer: FSM states, 3x5 digit font,
// glyph lookup, paddle clamp and score saturation.
`timescale 1ns/1ps
package pong_pkg;

    typedef enum logic {IDLE, EMIT} state_t;

    // Coordinate helpers work on a wide type so any CW fits; callers truncate back.
    localparam int CRD_W = 16;
    typedef logic [CRD_W-1:0] crd_t;

    // Each entry packs the five glyph rows top-to-bottom, row 0 in bits [14:12].
    localparam logic [14:0] FONT [10] = '{
        15'b111_101_101_101_111,
        15'b010_010_010_010_010,
        15'b111_001_111_100_111,
        15'b111_001_111_001_111,
        15'b101_101_111_001_001,
        15'b111_100_111_001_111,
        15'b111_100_111_101_111,
        15'b111_001_001_001_001,
        15'b111_101_111_101_111,
        15'b111_101_111_001_111
    };

    function automatic logic [2:0] glyph_row(input logic [3:0] digit, input logic [2:0] r);
        logic [14:0] g;
        g = (digit <= 4'd9) ? FONT[digit] : 15'd0;
        case (r)
            3'd0:    glyph_row = g[14:12];
            3'd1:    glyph_row = g[11:9];
            3'd2:    glyph_row = g[8:6];
            3'd3:    glyph_row = g[5:3];
            3'd4:    glyph_row = g[2:0];
            default: glyph_row = 3'b000;
        endcase
    endfunction

    function automatic crd_t clamp_coord(input crd_t v, input crd_t lo, input crd_t hi);
        if (v < lo)
            clamp_coord = lo;
        else if (v > hi)
            clamp_coord = hi;
        else
            clamp_coord = v;
    endfunction

    function automatic logic [3:0] sat_score(input logic [3:0] s);
        sat_score = (s > 4'd9) ? 4'd9 : s;
    endfunction

endpackage

// File: rtl/pong_frame_renderer_row_composer.sv
// Combinational row composer: ORs ball, paddles, dashed midline and score glyphs
// for one row. Optional full-width border rows under PONG_FRAME_BORDER_EN.
`timescale 1ns/1ps
module pong_row_composer
    import pong_pkg::*;
#(
    parameter int W           = 64,
    parameter int H           = 64,
    parameter int CW          = 6,
    parameter int PAD_H       = 6,
    parameter int PAD_W       = 2,
    parameter int MID_X       = 30,
    parameter int DASH_ON     = 2,
    parameter int DASH_PERIOD = 3,
    parameter int SC1_X       = 14,
    parameter int SC2_X       = 46,
    parameter int SC_Y        = 1
) (
    input  logic [CW-1:0] i_row,
    input  logic [CW-1:0] i_bx,
    input  logic [CW-1:0] i_by,
    input  logic [CW-1:0] i_p1y,
    input  logic [CW-1:0] i_p2y,
    input  logic [3:0]    i_sc1,
    input  logic [3:0]    i_sc2,
    output logic [W-1:0]  o_row_data
);

    // Two guard bits keep paddle-bottom sums from wrapping.
    localparam int AW = CW + 2;

    logic [AW-1:0] w_row_x;
    logic          w_ball_row;
    logic          w_p1_row;
    logic          w_p2_row;
    logic          w_mid;
    logic          w_sc_row;
    logic [2:0]    w_glyph_r;
    logic [2:0]    w_g1;
    logic [2:0]    w_g2;
    logic          w_border;

    assign w_row_x    = {2'b00, i_row};
    assign w_ball_row = (i_by == i_row) && ({2'b00, i_bx} < AW'(W)) && ({2'b00, i_by} < AW'(H));
    assign w_p1_row   = (w_row_x >= {2'b00, i_p1y}) && (w_row_x < ({2'b00, i_p1y} + AW'(PAD_H)));
    assign w_p2_row   = (w_row_x >= {2'b00, i_p2y}) && (w_row_x < ({2'b00, i_p2y} + AW'(PAD_H)));
    assign w_mid      = (i_row % CW'(DASH_PERIOD)) < CW'(DASH_ON);
    assign w_sc_row   = (w_row_x >= AW'(SC_Y)) && (w_row_x < AW'(SC_Y + 5));
    assign w_glyph_r  = 3'(w_row_x - AW'(SC_Y));
    assign w_g1       = glyph_row(i_sc1, w_glyph_r);
    assign w_g2       = glyph_row(i_sc2, w_glyph_r);

`ifdef PONG_FRAME_BORDER_EN
    assign w_border = (i_row == '0) || (i_row == CW'(H - 1));
`else
    assign w_border = 1'b0;
`endif

    // One generated slice per column; only in-matrix columns exist, so clipping is implicit.
    for (genvar gi = 0; gi < W; gi++) begin : g_col
        localparam logic [CW-1:0] COL = CW'(gi);
        localparam bit IS_P1  = (gi < PAD_W);
        localparam bit IS_P2  = (gi >= W - PAD_W);
        localparam bit IS_MID = (gi == MID_X) || (gi == MID_X + 1);

        logic w_s1;
        logic w_s2;

        if (gi >= SC1_X && gi < SC1_X + 3) begin : g_s1
            assign w_s1 = w_sc_row && w_g1[2 - (gi - SC1_X)];
        end else begin : g_no_s1
            assign w_s1 = 1'b0;
        end

        if (gi >= SC2_X && gi < SC2_X + 3) begin : g_s2
            assign w_s2 = w_sc_row && w_g2[2 - (gi - SC2_X)];
        end else begin : g_no_s2
            assign w_s2 = 1'b0;
        end

        assign o_row_data[gi] = (w_ball_row && (i_bx == COL))
                              || (IS_P1 && w_p1_row)
                              || (IS_P2 && w_p2_row)
                              || (IS_MID && w_mid)
                              || w_s1 || w_s2 || w_border;
    end

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong frame renderer: snapshots game state on frame_start and streams W x H rows
// over valid/ready. Border rows optional via PONG_FRAME_BORDER_EN.
`timescale 1ns/1ps
module pong_frame_renderer
    import pong_pkg::*;
#(
    parameter int W           = 64,
    parameter int H           = 64,
    parameter int CW          = 6,
    parameter int PAD_H       = 6,
    parameter int PAD_W       = 2,
    parameter int PAD_YMIN    = 5,
    parameter int PAD_YMAX    = 58,
    parameter int MID_X       = 30,
    parameter int DASH_ON     = 2,
    parameter int DASH_PERIOD = 3,
    parameter int SC1_X       = 14,
    parameter int SC2_X       = 46,
    parameter int SC_Y        = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [CW-1:0] bx,
    input  logic [CW-1:0] by,
    input  logic [CW-1:0] p1y,
    input  logic [CW-1:0] p2y,
    input  logic [3:0]    sc1,
    input  logic [3:0]    sc2,
    output logic          row_valid,
    input  logic          row_ready,
    output logic [CW-1:0] row_addr,
    output logic [W-1:0]  row_data,
    output logic          frame_busy,
    output logic          frame_done,
    output logic          frame_drop
);

    localparam logic [CW-1:0] LAST_ROW = CW'(H - 1);

    state_t        r_state;
    logic [CW-1:0] r_bx, r_by, r_p1y, r_p2y;
    logic [3:0]    r_sc1, r_sc2;
    logic [CW-1:0] r_row_addr;
    logic [W-1:0]  r_row_data;
    logic          r_valid, r_busy, r_done, r_drop;

    logic [CW-1:0] w_p1c, w_p2c;
    logic [3:0]    w_sc1s, w_sc2s;
    logic          w_live;
    logic          w_xfer;
    logic [CW-1:0] w_c_row, w_c_bx, w_c_by, w_c_p1y, w_c_p2y;
    logic [3:0]    w_c_sc1, w_c_sc2;
    logic [W-1:0]  w_comp_row;

    assign w_p1c  = CW'(clamp_coord(CRD_W'(p1y), CRD_W'(PAD_YMIN), CRD_W'(PAD_YMAX)));
    assign w_p2c  = CW'(clamp_coord(CRD_W'(p2y), CRD_W'(PAD_YMIN), CRD_W'(PAD_YMAX)));
    assign w_sc1s = sat_score(sc1);
    assign w_sc2s = sat_score(sc2);

    // In IDLE the composer sees the live (clamped) inputs so row 0 is ready one cycle
    // after frame_start; in EMIT it sees the snapshot and the row after the current one.
    assign w_live  = (r_state == IDLE);
    assign w_xfer  = r_valid && row_ready;
    assign w_c_row = w_live ? '0     : r_row_addr + CW'(1);
    assign w_c_bx  = w_live ? bx     : r_bx;
    assign w_c_by  = w_live ? by     : r_by;
    assign w_c_p1y = w_live ? w_p1c  : r_p1y;
    assign w_c_p2y = w_live ? w_p2c  : r_p2y;
    assign w_c_sc1 = w_live ? w_sc1s : r_sc1;
    assign w_c_sc2 = w_live ? w_sc2s : r_sc2;

    pong_row_composer #(
        .W           (W),
        .H           (H),
        .CW          (CW),
        .PAD_H       (PAD_H),
        .PAD_W       (PAD_W),
        .MID_X       (MID_X),
        .DASH_ON     (DASH_ON),
        .DASH_PERIOD (DASH_PERIOD),
        .SC1_X       (SC1_X),
        .SC2_X       (SC2_X),
        .SC_Y        (SC_Y)
    ) u_composer (
        .i_row      (w_c_row),
        .i_bx       (w_c_bx),
        .i_by       (w_c_by),
        .i_p1y      (w_c_p1y),
        .i_p2y      (w_c_p2y),
        .i_sc1      (w_c_sc1),
        .i_sc2      (w_c_sc2),
        .o_row_data (w_comp_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bx       <= '0;
            r_by       <= '0;
            r_p1y      <= '0;
            r_p2y      <= '0;
            r_sc1      <= '0;
            r_sc2      <= '0;
            r_row_addr <= '0;
            r_row_data <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_bx       <= bx;
                        r_by       <= by;
                        r_p1y      <= w_p1c;
                        r_p2y      <= w_p2c;
                        r_sc1      <= w_sc1s;
                        r_sc2      <= w_sc2s;
                        r_row_addr <= '0;
                        r_row_data <= w_comp_row;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (frame_start)
                        r_drop <= 1'b1;
                    if (w_xfer) begin
                        if (r_row_addr == LAST_ROW) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_row_addr <= w_c_row;
                            r_row_data <= w_comp_row;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign row_valid  = r_valid;
    assign row_addr   = r_row_addr;
    assign row_data   = r_row_data;
    assign frame_busy = r_busy;
    assign frame_done = r_done;
    assign frame_drop = r_drop;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Scoreboard bench for pong_frame_renderer: expected rows are queued at frame_start,
// a negedge monitor pops and compares each accepted row. Honours PONG_FRAME_BORDER_EN.
`timescale 1ns/1ps
module tb_pong_frame_renderer;

    localparam int W = 64, H = 64, CW = 6;
    localparam int PAD_H = 6, PAD_W = 2, PAD_YMIN = 5, PAD_YMAX = 58;
    localparam int MID_X = 30, DASH_ON = 2, DASH_PERIOD = 3;
    localparam int SC1_X = 14, SC2_X = 46, SC_Y = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [CW-1:0] bx = '0, by = '0, p1y = '0, p2y = '0;
    logic [3:0]    sc1 = '0, sc2 = '0;
    logic          row_valid;
    logic          row_ready = 1'b1;
    logic [CW-1:0] row_addr;
    logic [W-1:0]  row_data;
    logic          frame_busy, frame_done, frame_drop;

    always #5 clk = ~clk;

    pong_frame_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bx          (bx),
        .by          (by),
        .p1y         (p1y),
        .p2y         (p2y),
        .sc1         (sc1),
        .sc2         (sc2),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_addr    (row_addr),
        .row_data    (row_data),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .frame_drop  (frame_drop)
    );

    typedef struct {
        logic [CW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] cap [H];
    int font [10][5] = '{'{7,5,5,5,7}, '{2,2,2,2,2}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
                         '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}};
    int n_vec = 0, n_err = 0, done_cnt = 0, xfer_cnt = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] model_row(input int r, input int xb, input int yb,
                                               input int p1, input int p2, input int s1, input int s2);
        logic [W-1:0] v;
        int c1, c2, d1, d2;
        v  = '0;
        c1 = (p1 < PAD_YMIN) ? PAD_YMIN : (p1 > PAD_YMAX) ? PAD_YMAX : p1;
        c2 = (p2 < PAD_YMIN) ? PAD_YMIN : (p2 > PAD_YMAX) ? PAD_YMAX : p2;
        d1 = (s1 > 9) ? 9 : s1;
        d2 = (s2 > 9) ? 9 : s2;
        for (int x = 0; x < W; x++) begin
            if (x == xb && r == yb && xb < W && yb < H) v[x] = 1'b1;
            if (x < PAD_W && r >= c1 && r < c1 + PAD_H) v[x] = 1'b1;
            if (x >= W - PAD_W && r >= c2 && r < c2 + PAD_H) v[x] = 1'b1;
            if ((x == MID_X || x == MID_X + 1) && (r % DASH_PERIOD) < DASH_ON) v[x] = 1'b1;
            if (r >= SC_Y && r < SC_Y + 5) begin
                if (x >= SC1_X && x < SC1_X + 3 && ((font[d1][r-SC_Y] >> (2 - (x - SC1_X))) & 1) == 1)
                    v[x] = 1'b1;
                if (x >= SC2_X && x < SC2_X + 3 && ((font[d2][r-SC_Y] >> (2 - (x - SC2_X))) & 1) == 1)
                    v[x] = 1'b1;
            end
`ifdef PONG_FRAME_BORDER_EN
            if (r == 0 || r == H - 1) v[x] = 1'b1;
`endif
        end
        return v;
    endfunction

    task automatic start_frame(input int xb, input int yb, input int p1, input int p2,
                               input int s1, input int s2);
        exp_t e;
        bx = CW'(xb); by = CW'(yb); p1y = CW'(p1); p2y = CW'(p2);
        sc1 = 4'(s1); sc2 = 4'(s2);
        for (int r = 0; r < H; r++) begin
            e.addr = CW'(r);
            e.data = model_row(r, xb, yb, p1, p2, s1, s2);
            exp_q.push_back(e);
        end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("latency_valid", row_valid, 1);
        chk("latency_addr", row_addr, 0);
        chk("latency_busy", frame_busy, 1);
    endtask

    task automatic wait_done(input bit rnd, output int n);
        n = 0;
        while (!frame_done && n < 2000) begin
            if (rnd) row_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        row_ready = 1'b1;
        if (!frame_done) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no frame_done after %0d cycles, expected one", n);
        end
    endtask

    task automatic wait_row(input int target);
        int k;
        k = 0;
        while (row_addr != CW'(target) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (row_addr != CW'(target)) begin
            n_vec++; n_err++;
            $display("FAIL row_timeout: got row %0d, expected row %0d", row_addr, target);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, row_valid, 0);
        chk({tag, "_addr"}, row_addr, 0);
        chk({tag, "_data"}, row_data, 0);
        chk({tag, "_busy"}, frame_busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_drop"}, frame_drop, 0);
    endtask

    // Monitor: samples on the falling edge, when inputs and outputs are settled.
    logic          prev_v = 1'b0, prev_r = 1'b0, have_prev = 1'b0;
    logic [CW-1:0] prev_a;
    logic [W-1:0]  prev_d;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_prev = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (have_prev && prev_v && !prev_r) begin
                chk("stall_valid", row_valid, 1);
                chk("stall_addr", row_addr, prev_a);
                chk("stall_data", row_data, prev_d);
            end
            if (row_valid && row_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_row: got row %0d, expected no transfer", row_addr);
                end else begin
                    e = exp_q.pop_front();
                    $display("row %0d data %h", row_addr, row_data);
                    chk("row_addr", row_addr, e.addr);
                    chk("row_data", row_data, e.data);
                end
                cap[row_addr] = row_data;
                xfer_cnt++;
            end
            prev_v = row_valid; prev_r = row_ready; prev_a = row_addr; prev_d = row_data;
            have_prev = 1'b1;
        end
    end

    int n, d0, x0;
    logic [2:0] g9 [5] = '{3'b111, 3'b101, 3'b111, 3'b100, 3'b111};
    logic [2:0] g3 [5] = '{3'b111, 3'b100, 3'b111, 3'b100, 3'b111};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Frame A: back-to-back, clamped p2, saturated sc2.
        d0 = done_cnt;
        start_frame(10, 20, 30, 2, 3, 12);
        wait_done(1'b0, n);
        chk("a_cycles", n, 64);
        chk("a_end_valid", row_valid, 0);
        chk("a_end_busy", frame_busy, 0);
        @(posedge clk); #1;
        chk("a_done_width", frame_done, 0);
        chk("a_done_count", done_cnt - d0, 1);
        chk("a_queue_empty", exp_q.size(), 0);
        chk("a_ball", cap[20][10], 1);
        for (int r = 3; r <= 12; r++) chk("a_p2", cap[r][63:62], (r >= 5 && r <= 10) ? 2'b11 : 2'b00);
        for (int r = 28; r <= 37; r++) chk("a_p1", cap[r][1:0], (r >= 30 && r <= 35) ? 2'b11 : 2'b00);
        for (int r = 0; r < 5; r++) chk("a_sc2_nine", cap[SC_Y+r][48:46], g9[r]);
        for (int r = 0; r < 5; r++) chk("a_sc1_three", cap[SC_Y+r][16:14], g3[r]);
        for (int r = 0; r < H; r++) chk("a_midline", cap[r][31:30], ((r % 3) < 2) ? 2'b11 : 2'b00);
`ifdef PONG_FRAME_BORDER_EN
        chk("a_border_top", cap[0], {W{1'b1}});
        chk("a_border_bot", cap[63], {W{1'b1}});
`else
        chk("a_row0_mid_only", cap[0], 64'h0000_0000_C000_0000);
        chk("a_row63_mid_only", cap[63], 64'h0000_0000_C000_0000);
`endif

        // Frame B: random backpressure, both paddles clamped.
        x0 = xfer_cnt;
        start_frame(63, 63, 0, 60, 9, 0);
        wait_done(1'b1, n);
        @(posedge clk); #1;
        chk("b_xfers", xfer_cnt - x0, 64);
        chk("b_queue_empty", exp_q.size(), 0);
        chk("b_p1_clamp_lo", cap[4][1:0], 2'b00);
        chk("b_p1_clamp_in", cap[5][1:0], 2'b11);
        chk("b_p2_clamp_lo", cap[57][63:62], 2'b00);
        chk("b_p2_clamp_in", cap[58][63:62], 2'b11);

        // Frame C: frame_start and bx change mid-frame are ignored; drop sticks.
        d0 = done_cnt;
        start_frame(40, 33, 58, 59, 15, 7);
        wait_row(17);
        frame_start = 1'b1;
        bx = 6'd5;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("c_drop_set", frame_drop, 1);
        chk("c_still_busy", frame_busy, 1);
        wait_done(1'b0, n);
        chk("c_cycles", n, 46);
        chk("c_ball_kept", cap[33][40], 1);
        chk("c_ball_new_col", cap[33][5], 0);
        chk("c_sc1_sat_r1", cap[2][16:14], 3'b101);
        chk("c_sc1_sat_r3", cap[4][16:14], 3'b100);

        // Frame D: started on the frame_done cycle.
        start_frame(0, 0, 6, 57, 0, 1);
        chk("d_drop_sticky", frame_drop, 1);
        wait_done(1'b0, n);
        @(posedge clk); #1;
        chk("cd_done_count", done_cnt - d0, 2);
        chk("d_queue_empty", exp_q.size(), 0);
        chk("d_sc2_one", cap[3][48:46], 3'b010);
        chk("d_p1_top", cap[6][1:0], 2'b11);
        chk("d_p1_above", cap[5][1:0], 2'b00);
        chk("d_drop_still", frame_drop, 1);

        // Frame E: reset at row 40 abandons the frame.
        start_frame(22, 44, 20, 40, 5, 6);
        wait_row(40);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("mid_reset");
        d0 = done_cnt;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("e_no_done", done_cnt - d0, 0);
        chk("e_idle_valid", row_valid, 0);

        // Frame F: restarts cleanly at row 0.
        x0 = xfer_cnt;
        start_frame(7, 7, 63, 0, 8, 4);
        wait_done(1'b0, n);
        chk("f_cycles", n, 64);
        @(posedge clk); #1;
        chk("f_xfers", xfer_cnt - x0, 64);
        chk("f_queue_empty", exp_q.size(), 0);
        chk("f_drop_clear", frame_drop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
